// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default timing constants for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W             = 3;
    localparam int unsigned CNT_W               = 10;
    localparam int unsigned RST_PIPE_CYCLES_DEF = 2;
    localparam int unsigned DC_TIMEOUT_DEF      = 255;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        LDUSE  = 3'd1,
        DCWAIT = 3'd2,
        DCFIN  = 3'd3,
        FLUSH  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/stall_delay_line.sv
// Two-deep history of a stall level plus a first-cycle pulse derived from flops only.
module stall_delay_line (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic stall_dly,
    output logic stall_dly2,
    output logic stall_1shot
);

    // Shift the stall level through two flops; only the core reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_dly  <= 1'b0;
            stall_dly2 <= 1'b0;
        end else begin
            stall_dly  <= stall;
            stall_dly2 <= stall_dly;
        end
    end

    // Both operands are registered, so the pulse cannot glitch.
    assign stall_1shot = stall & ~stall_dly;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: D-cache freeze, load-use bubble, pipeline flush, cache watchdog.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RST_PIPE_CYCLES = RST_PIPE_CYCLES_DEF,
    parameter int unsigned DC_TIMEOUT      = DC_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dc_miss,
    input  logic               dc_stall_fin,
    input  logic               ld_use_hzd,
    input  logic               jmp_purge_ex,
    input  logic               flush_req,
    output logic               stall,
    output logic               stall_1shot,
    output logic               stall_dly,
    output logic               stall_dly2,
    output logic               stall_id,
    output logic               rst_pipe,
    output logic               dc_timeout_err,
    output logic [STATE_W-1:0] ctrl_state
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(RST_PIPE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(DC_TIMEOUT - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             err_q, err_d;
    logic             stall_q;
    logic             rst_pipe_q;

    // State, counter, pending-flush and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= 1'b0;
            rst_pipe_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
            stall_q      <= (state_d == DCWAIT);
            rst_pipe_q   <= (state_d == FLUSH);
        end
    end

    // Next-state, counter and load-use bubble decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        err_d        = err_q;
        stall_id     = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (dc_miss) begin
                    state_d = DCWAIT;
                    cnt_d   = '0;
                end else if (ld_use_hzd && !jmp_purge_ex) begin
                    state_d  = LDUSE;
                    stall_id = 1'b1;
                end
            end

            // Single bubble cycle; a still-present hazard is the same one.
            LDUSE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (dc_miss) begin
                    state_d = DCWAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            // Flush requests are parked until the fill completes; fill completion beats timeout.
            DCWAIT: begin
                if (flush_req) begin
                    flush_pend_d = 1'b1;
                end
                if (dc_stall_fin) begin
                    state_d = DCFIN;
                end else if (cnt_q == WD_LAST) begin
                    err_d        = 1'b1;
                    state_d      = FLUSH;
                    cnt_d        = FLUSH_LOAD;
                    flush_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Release cycle while the MA instruction retires; dc_miss is stale here.
            DCFIN: begin
                if (flush_pend_q || flush_req) begin
                    state_d      = FLUSH;
                    cnt_d        = FLUSH_LOAD;
                    flush_pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            // Hold rst_pipe; a repeated request restarts the count.
            FLUSH: begin
                if (flush_req) begin
                    cnt_d = FLUSH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall          = stall_q;
    assign rst_pipe       = rst_pipe_q;
    assign dc_timeout_err = err_q;
    assign ctrl_state     = state_q;

    // Delayed stall views consumed by EX rollback logic.
    stall_delay_line u_stall_delay_line (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall_q),
        .stall_dly   (stall_dly),
        .stall_dly2  (stall_dly2),
        .stall_1shot (stall_1shot)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios then randomized traffic.
module tb_pipe_stall_ctrl;

    localparam int unsigned RPC = 2;
    localparam int unsigned DTO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       dc_miss, dc_stall_fin, ld_use_hzd, jmp_purge_ex, flush_req;
    logic       stall, stall_1shot, stall_dly, stall_dly2, stall_id, rst_pipe, dc_timeout_err;
    logic [2:0] ctrl_state;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .RST_PIPE_CYCLES (RPC),
        .DC_TIMEOUT      (DTO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dc_miss        (dc_miss),
        .dc_stall_fin   (dc_stall_fin),
        .ld_use_hzd     (ld_use_hzd),
        .jmp_purge_ex   (jmp_purge_ex),
        .flush_req      (flush_req),
        .stall          (stall),
        .stall_1shot    (stall_1shot),
        .stall_dly      (stall_dly),
        .stall_dly2     (stall_dly2),
        .stall_id       (stall_id),
        .rst_pipe       (rst_pipe),
        .dc_timeout_err (dc_timeout_err),
        .ctrl_state     (ctrl_state)
    );

    // Vector: stall, 1shot, dly, dly2, stall_id, rst_pipe, err, state[2:0]
    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase flags plus plain cycle counts.
    bit m_wait, m_fin, m_flush, m_lduse, m_pend, m_err, m_d1, m_d2;
    int m_waited, m_left;

    function automatic logic [9:0] act_vec();
        return {stall, stall_1shot, stall_dly, stall_dly2, stall_id,
                rst_pipe, dc_timeout_err, ctrl_state};
    endfunction

    function automatic logic [2:0] m_code();
        if (m_lduse) return 3'd1;
        if (m_wait)  return 3'd2;
        if (m_fin)   return 3'd3;
        if (m_flush) return 3'd4;
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_fin = 0; m_flush = 0; m_lduse = 0;
        m_pend = 0; m_err = 0; m_d1 = 0; m_d2 = 0;
        m_waited = 0; m_left = 0;
    endtask

    task automatic enter_flush();
        m_flush = 1;
        m_left  = int'(RPC);
    endtask

    task automatic enter_wait();
        m_wait   = 1;
        m_waited = 0;
    endtask

    // Push what the DUT must show this cycle, then advance the model across the clock edge.
    task automatic model_cycle(input bit miss, input bit fin, input bit ld, input bit jmp, input bit fl);
        bit idle;
        bit s;
        bit sid;
        int r;
        idle = !(m_wait || m_fin || m_flush || m_lduse);
        s    = m_wait;
        sid  = idle && !fl && !miss && ld && !jmp;
        exp_q.push_back({s, s & ~m_d1, m_d1, m_d2, sid, m_flush, m_err, m_code()});
        if (m_flush) begin
            r = fl ? int'(RPC) : m_left - 1;
            if (r == 0) m_flush = 0;
            m_left = r;
        end else if (m_wait) begin
            m_waited++;
            if (fl) m_pend = 1;
            if (fin) begin
                m_wait = 0;
                m_fin  = 1;
            end else if (m_waited == int'(DTO)) begin
                m_err  = 1;
                m_pend = 0;
                m_wait = 0;
                enter_flush();
            end
        end else if (m_fin) begin
            m_fin = 0;
            if (m_pend || fl) begin
                m_pend = 0;
                enter_flush();
            end
        end else if (m_lduse) begin
            m_lduse = 0;
            if (fl) enter_flush();
            else if (miss) enter_wait();
        end else begin
            if (fl) enter_flush();
            else if (miss) enter_wait();
            else if (ld && !jmp) m_lduse = 1;
        end
        m_d2 = m_d1;
        m_d1 = s;
    endtask

    task automatic cyc(input bit miss, input bit fin, input bit ld, input bit jmp, input bit fl);
        @(posedge clk);
        #2;
        rst          = 1'b0;
        dc_miss      = miss;
        dc_stall_fin = fin;
        ld_use_hzd   = ld;
        jmp_purge_ex = jmp;
        flush_req    = fl;
        model_cycle(miss, fin, ld, jmp, fl);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Reset raised between edges; outputs must clear before the next edge.
    task automatic async_rst();
        @(posedge clk);
        #2;
        rst = 1'b1;
        dc_miss = 0; dc_stall_fin = 0; ld_use_hzd = 0; jmp_purge_ex = 0; flush_req = 0;
        #1;
        n_cmp++;
        if (act_vec() !== 10'd0) begin
            n_bad++;
            $display("FAIL async_reset t=%0t got=%b exp=%b", $time, act_vec(), 10'd0);
        end
        model_reset();
        exp_q.push_back(10'd0);
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        logic [9:0] e;
        logic [9:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_vec();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got={stl,1s,d1,d2,sid,rp,err,st}=%b exp=%b",
                         $time, a, e);
            end
        end
    end

    initial begin
        int miss_left;
        bit m;
        rst = 1'b1;
        dc_miss = 0; dc_stall_fin = 0; ld_use_hzd = 0; jmp_purge_ex = 0; flush_req = 0;
        model_reset();

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) async_rst();

        // Cache miss freeze with fill completion.
        idle_n(10);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        idle_n(4);

        // Load-use bubble, then suppressed by jump purge.
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); idle_n(2);
        cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 1, 0); idle_n(2);

        // Flush, then flush extended by a second request.
        cyc(0, 0, 0, 0, 1); idle_n(3);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1); idle_n(4);

        // Flush request deferred behind a fill.
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        idle_n(5);

        // Watchdog timeout, sticky error, then fill finishing in the last allowed cycle.
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0);
        idle_n(6);
        async_rst();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < int'(DTO) - 1; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        idle_n(4);

        // Asynchronous reset in the middle of a cache wait.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        async_rst();
        idle_n(3);

        // Randomized traffic.
        miss_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 4) begin
                async_rst();
            end else begin
                if (miss_left > 0) begin
                    miss_left--;
                    m = 1;
                end else if ($urandom_range(99) < 8) begin
                    miss_left = int'($urandom_range(12));
                    m = 1;
                end else begin
                    m = 0;
                end
                cyc(m, $urandom_range(99) < 12, $urandom_range(99) < 30,
                    $urandom_range(99) < 25, $urandom_range(99) < 4);
            end
        end
        idle_n(3);

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. It owns the global stall/flush timing that the EX stage and its neighbours consume: `stall`, `stall_1shot`, `stall_dly`, `stall_dly2`, `rst_pipe`, plus the ID-side load-use bubble. It arbitrates between data-cache miss freezes, load-use hazards and pipeline-flush requests, and runs a watchdog on cache waits.

Parameters:
RST_PIPE_CYCLES, 2, number of cycles `rst_pipe` is held per flush (legal range 1..15)
DC_TIMEOUT, 255, max cycles in cache wait before forced flush (legal range 2..1023)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
dc_miss  in  1  level; MA-stage load/store missed in D-cache, freeze request
dc_stall_fin  in  1  1-cycle pulse; cache fill/writeback complete
ld_use_hzd  in  1  ID instruction sources rd of a load currently in EX
jmp_purge_ex  in  1  EX jump/ecall taken this cycle
flush_req  in  1  1-cycle pulse; request pipeline clear (debug/soft restart)
stall  out  1  global freeze of IF..MA registers
stall_1shot  out  1  first cycle of a stall episode
stall_dly  out  1  `stall` delayed 1 cycle
stall_dly2  out  1  `stall` delayed 2 cycles
stall_id  out  1  freeze IF/ID, inject bubble into EX (load-use)
rst_pipe  out  1  synchronous clear of pipeline registers
dc_timeout_err  out  1  sticky watchdog error
ctrl_state  out  3  current FSM state (debug)

Behaviour:
- Reset: state IDLE, all counters 0, flush_pend 0, every output 0.
- States: IDLE, LDUSE, DCWAIT, DCFIN, FLUSH.
- IDLE transitions, in priority order: `flush_req` -> FLUSH; `dc_miss` -> DCWAIT; `ld_use_hzd & ~jmp_purge_ex` -> LDUSE; otherwise IDLE.
- `stall_id` is Mealy and equals exactly the IDLE->LDUSE condition, so the bubble enters EX the same cycle the hazard is seen.
- LDUSE: lasts exactly 1 cycle. `ld_use_hzd` is ignored there (no double bubble). Exits: `flush_req` -> FLUSH; `dc_miss` -> DCWAIT; otherwise IDLE.
- DCWAIT: `stall` = 1 (Moore).
  - Watchdog counter starts at 0 on entry and increments each cycle.
  - `flush_req` received here sets flush_pend; the flush is deferred, never aborting a fill.
  - `dc_stall_fin` -> DCFIN.
  - Otherwise, when the counter reaches DC_TIMEOUT-1: set `dc_timeout_err`, go to FLUSH, clear flush_pend.
  - If `dc_stall_fin` arrives in the timeout cycle, `dc_stall_fin` wins.
- DCFIN: 1 cycle, `stall` = 0 (release). `dc_miss` is ignored this cycle because the MA instruction is still retiring. Exits: flush_pend or `flush_req` -> FLUSH (clear flush_pend); otherwise IDLE.
- `stall` latency: deasserts the cycle after the `dc_stall_fin` pulse; asserts the cycle after `dc_miss` is first sampled in IDLE/LDUSE.
- FLUSH: `rst_pipe` = 1, `stall` = 0, cycle counter loads RST_PIPE_CYCLES-1 on entry and counts down.
  - Exit to IDLE after the cycle where the counter is 0, so `rst_pipe` is high exactly RST_PIPE_CYCLES cycles.
  - `flush_req` inside FLUSH reloads the counter (extends the flush).
  - `dc_miss` and `ld_use_hzd` are ignored.
- Delayed stall outputs:
  - `stall_dly` and `stall_dly2` are a 2-flop shift of `stall`, cleared by `rst`.
  - They are not cleared by `rst_pipe`, so rollback timing survives a flush.
- `stall_1shot` = `stall & ~stall_dly`, combinational from registered signals, therefore glitch-free.
- `dc_timeout_err` is cleared only by `rst`.
- `dc_stall_fin` outside DCWAIT is ignored.
- Async reset mid-DCWAIT or mid-FLUSH: immediate return to IDLE, all outputs 0, no residual flush.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding IDLE=3'd0, LDUSE=3'd1, DCWAIT=3'd2, DCFIN=3'd3, FLUSH=3'd4;
  - default constants for RST_PIPE_CYCLES and DC_TIMEOUT.
- One natural sub-module: stall_delay_line (`stall` -> `stall_dly`, `stall_dly2`, `stall_1shot`), reusable by the I-cache controller.

Test Plan:
1. Apply `rst`, hold 3 cycles, release. Expect all outputs 0 and `ctrl_state` = 0. Assert `dc_miss` at cycle 10 and pulse `dc_stall_fin` at cycle 15. Expect:
   - `stall` high cycles 11-15;
   - `stall_1shot` high cycle 11 only;
   - `stall_dly` high 12-16 and `stall_dly2` high 13-17;
   - `ctrl_state` = 3 at cycle 16.
2. Drive `ld_use_hzd` = 1 for 2 consecutive cycles, `jmp_purge_ex` = 0. Expect `stall_id` high in the first cycle only, `ctrl_state` = 1 then 0, `stall` never high. Repeat with `jmp_purge_ex` = 1: expect no `stall_id`.
3. Pulse `flush_req` in IDLE with RST_PIPE_CYCLES = 2. Expect `rst_pipe` high exactly 2 cycles. A second pulse during the 1st `rst_pipe` cycle must extend `rst_pipe` to 3 cycles total.
4. `dc_miss` held, `flush_req` pulsed 2 cycles later, `dc_stall_fin` 5 cycles later. Expect:
   - no `rst_pipe` while `stall` = 1;
   - one DCFIN cycle with `stall` = 0;
   - then `rst_pipe` for 2 cycles.
5. With DC_TIMEOUT = 8: `dc_miss` held and no `dc_stall_fin`. Expect `stall` high exactly 8 cycles, then `dc_timeout_err` = 1 (sticky) and `rst_pipe` for 2 cycles. Verify the error stays 1 until `rst`. Separately, `dc_stall_fin` in the 8th cycle must yield no error.
6. Assert `rst` asynchronously mid-DCWAIT (between clock edges). Expect `stall`, `stall_dly`, `stall_dly2` and `ctrl_state` to go to 0 immediately, without waiting for a clock edge.
